gmem_port_arbiter: RTL and testbench

Round-robin arbiter that shares one fixed-latency `graph_memory` read port between up to NUM_REQ requesters, such as several `graph_fetch` instances or the fetch engines of parallel search processors. Each requester has a one-deep request register, and requests are issued to memory at most one per cycle. Every issued request is tagged with its requester index, and each memory response is routed back to the requester that issued it. The block sits between the requesters' `mem_req_out`/`mem_valid_out` pairs and a single memory port (`data_addra`/`data_validina`).

---
 rtl/gmem_port_arbiter_if.sv | 28 ++
 rtl/gmem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_gmem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gmem_port_arbiter_if.sv
// Shared graph_memory read port: requester-side handshake plus the single memory port.
interface gmem_port_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]                 req_valid_in;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_in;
   logic [NUM_REQ-1:0]                 req_ready_out;
   logic [NUM_REQ-1:0]                 resp_valid_out;
   logic [DATA_WIDTH-1:0]              resp_data_out;
   logic [ADDR_WIDTH-1:0]              mem_req_out;
   logic                               mem_valid_out;
   logic [DATA_WIDTH-1:0]              mem_data_in;
   logic                               mem_valid_in;

   // arbiter side
   modport slave (
      input  req_valid_in, req_addr_in, mem_data_in, mem_valid_in,
      output req_ready_out, resp_valid_out, resp_data_out, mem_req_out, mem_valid_out
   );

   // requesters + memory side
   modport master (
      output req_valid_in, req_addr_in, mem_data_in, mem_valid_in,
      input  req_ready_out, resp_valid_out, resp_data_out, mem_req_out, mem_valid_out
   );
endinterface

// File: rtl/gmem_port_arbiter.sv
// gmem_port_arbiter: round-robin sharing of one fixed-latency graph_memory read port.
// Requests are tagged with their requester index; the tag rides a shift register
// aligned to the memory latency so each response is routed back to its issuer.

// One-deep request register per requester.
module gmem_req_slot #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  gnt,
   output logic                  pend_v,
   output logic [ADDR_WIDTH-1:0] pend_a
);
   // ready is ~pend_v, so a grant and a refill never land on the same edge
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pend_v <= 1'b0;
         pend_a <= '0;
      end else if (gnt) begin
         pend_v <= 1'b0;
      end else if (req_valid && !pend_v) begin
         pend_v <= 1'b1;
         pend_a <= req_addr;
      end
   end
endmodule

module gmem_port_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic                clk_in,
   input  logic                rst_in,
   gmem_port_arbiter_if.slave  bus,
   output logic                idle_out,
   output logic                err_out
);
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   logic [NUM_REQ-1:0]                 pend_v;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] pend_a;
   logic [NUM_REQ-1:0]                 gnt;
   logic [IW-1:0]                      rr_ptr, gidx, cand;
   logic                               found;

   // Stage 0 is loaded on the same edge as mem_valid_out, so the tail
   // (stage MEM_LATENCY) lines up with the matching mem_valid_in.
   logic [MEM_LATENCY:0]               vld_pipe;
   logic [MEM_LATENCY:0][IW-1:0]       id_pipe;
   logic                               tail_v;
   logic [IW-1:0]                      tail_id;
   logic [DATA_WIDTH-1:0]              resp_data_q;

   gmem_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot [NUM_REQ-1:0] (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .req_valid (bus.req_valid_in),
      .req_addr  (bus.req_addr_in),
      .gnt       (gnt),
      .pend_v    (pend_v),
      .pend_a    (pend_a)
   );

   assign bus.req_ready_out = ~pend_v;
   assign bus.resp_data_out = resp_data_q;
   assign tail_v            = vld_pipe[MEM_LATENCY];
   assign tail_id           = id_pipe[MEM_LATENCY];

   // round-robin search starting one past the last grant, wrapping upward
   always_comb begin
      found = 1'b0;
      gidx  = rr_ptr;
      cand  = rr_ptr;
      gnt   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + IW'(1);
         if (!found && pend_v[cand]) begin
            found = 1'b1;
            gidx  = cand;
         end
      end
      if (found) gnt[gidx] = 1'b1;
   end

   // issue the granted address; mem_req_out holds when nothing is granted
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rr_ptr            <= IW'(NUM_REQ - 1);
         bus.mem_valid_out <= 1'b0;
         bus.mem_req_out   <= '0;
      end else begin
         bus.mem_valid_out <= found;
         if (found) begin
            rr_ptr          <= gidx;
            bus.mem_req_out <= pend_a[gidx];
         end
      end
   end

   // tag pipeline advances every cycle
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         vld_pipe <= '0;
         id_pipe  <= '0;
      end else begin
         vld_pipe <= {vld_pipe[MEM_LATENCY-1:0], found};
         id_pipe  <= {id_pipe[MEM_LATENCY-1:0], gidx};
      end
   end

   // route responses by tag; any tag/data mismatch sets the sticky error
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         bus.resp_valid_out <= '0;
         resp_data_q        <= '0;
         err_out            <= 1'b0;
      end else begin
         bus.resp_valid_out <= (tail_v && bus.mem_valid_in) ? (ONE_HOT0 << tail_id) : '0;
         if (tail_v && bus.mem_valid_in) resp_data_q <= bus.mem_data_in;
         if (tail_v != bus.mem_valid_in) err_out <= 1'b1;
      end
   end

   // idle: nothing pending, nothing in flight, nothing being issued
   always_ff @(posedge clk_in) begin
      if (rst_in) idle_out <= 1'b1;
      else        idle_out <= ~|pend_v & ~|vld_pipe & ~bus.mem_valid_out;
   end
endmodule

// File: tb/tb_gmem_port_arbiter.sv
// Scoreboard bench for gmem_port_arbiter: stimulus pushes expected issues and
// responses (with hand-computed cycles), a negedge monitor pops and compares.
module tb_gmem_port_arbiter;
   localparam int N = 4, AW = 32, DW = 32, L = 2;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   logic idle_out, err_out;
   int   cyc = 0, n_vec = 0, n_err = 0;
   bit   spur = 1'b0;

   gmem_port_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

   gmem_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(L)) dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .bus      (bus.slave),
      .idle_out (idle_out),
      .err_out  (err_out)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {logic [AW-1:0] addr; int cyc;} mexp_t;
   typedef struct {logic [N-1:0] hot; logic [DW-1:0] data; int cyc;} rexp_t;
   typedef struct {logic [DW-1:0] data; bit drop;} mword_t;
   typedef struct {logic [DW-1:0] data; int due;} mdel_t;

   mexp_t  mem_q[$];
   rexp_t  resp_q[$];
   mword_t md_q[$];
   mdel_t  dl_q[$];

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic exp_issue(input logic [AW-1:0] a, input int icyc);
      mem_q.push_back('{a, icyc});
   endtask

   task automatic exp_req(input logic [AW-1:0] a, input int id, input int icyc, input logic [DW-1:0] d);
      logic [N-1:0] h;
      h = '0;
      h[id] = 1'b1;
      exp_issue(a, icyc);
      resp_q.push_back('{h, d, icyc + L + 1});
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ready"},      bus.req_ready_out,  4'hF);
      chk({tag, "_mem_valid"},  bus.mem_valid_out,  0);
      chk({tag, "_mem_req"},    bus.mem_req_out,    0);
      chk({tag, "_resp_valid"}, bus.resp_valid_out, 0);
      chk({tag, "_resp_data"},  bus.resp_data_out,  0);
      chk({tag, "_err"},        err_out,            0);
      chk({tag, "_idle"},       idle_out,           1);
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      bus.req_valid_in = '0;
      tick();
      rst_in = 1'b0;
      mem_q.delete();
      resp_q.delete();
      md_q.delete();
   endtask

   // monitor: compare every issue and every response against the scoreboard
   always @(negedge clk_in) begin
      mexp_t  me;
      rexp_t  re;
      mword_t w;
      if (!rst_in) begin
         if (bus.mem_valid_out) begin
            if (mem_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL mem_issue: unexpected addr %0h at cycle %0d", bus.mem_req_out, cyc);
            end else begin
               me = mem_q.pop_front();
               chk("mem_req_addr", bus.mem_req_out, me.addr);
               chk("mem_req_cycle", cyc, me.cyc);
            end
            if (md_q.size() != 0) w = md_q.pop_front();
            else begin
               w.data = mem_word(bus.mem_req_out);
               w.drop = 1'b0;
            end
            if (!w.drop) dl_q.push_back('{w.data, cyc + L});
         end
         if (bus.resp_valid_out != '0) begin
            if (resp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL resp_route: unexpected valid %b data %0h at cycle %0d",
                        bus.resp_valid_out, bus.resp_data_out, cyc);
            end else begin
               re = resp_q.pop_front();
               chk("resp_onehot", bus.resp_valid_out, re.hot);
               chk("resp_data", bus.resp_data_out, re.data);
               chk("resp_cycle", cyc, re.cyc);
            end
         end
      end
   end

   // fixed-latency memory model sharing rst_in
   always @(posedge clk_in) begin
      mdel_t d;
      #2;
      bus.mem_valid_in = 1'b0;
      if (rst_in) dl_q.delete();
      else if (dl_q.size() != 0 && dl_q[0].due == cyc) begin
         d = dl_q.pop_front();
         bus.mem_valid_in = 1'b1;
         bus.mem_data_in  = d.data;
      end
      if (spur) begin
         bus.mem_valid_in = 1'b1;
         bus.mem_data_in  = 32'hEE;
         spur = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0, c0, c2;
      bus.req_valid_in = '0;
      bus.req_addr_in  = '0;
      tick(3);
      rst_in = 1'b0;
      chk_reset("por");

      // single request: r1 @0x10, data 0xAB
      t0 = cyc;
      bus.req_valid_in = 4'b0010;
      bus.req_addr_in[1] = 32'h10;
      md_q.push_back('{32'hAB, 1'b0});
      exp_req(32'h10, 1, t0 + 2, 32'hAB);
      tick();
      bus.req_valid_in = '0;
      tick();
      chk("t1_busy", idle_out, 0);
      tick(4);
      chk("t1_idle", idle_out, 1);
      chk("t1_drained", mem_q.size() + resp_q.size(), 0);

      // all four at once after reset
      do_reset();
      t0 = cyc;
      bus.req_valid_in = 4'hF;
      for (int i = 0; i < N; i++) begin
         bus.req_addr_in[i] = 32'h100 + i;
         md_q.push_back('{32'hA0 + i, 1'b0});
         exp_req(32'h100 + i, i, t0 + 2 + i, 32'hA0 + i);
      end
      tick();
      bus.req_valid_in = '0;
      tick(9);
      chk("t2_idle", idle_out, 1);
      chk("t2_drained", mem_q.size() + resp_q.size(), 0);

      // fairness: r0 and r2 re-request whenever ready; issues alternate every cycle
      t0 = cyc;
      for (int j = 0; j < 10; j++) begin
         exp_req(32'h200 + j, 0, t0 + 2*j + 2, mem_word(32'h200 + j));
         exp_req(32'h300 + j, 2, t0 + 2*j + 3, mem_word(32'h300 + j));
      end
      c0 = 0; c2 = 0;
      for (int k = 0; k < 20; k++) begin
         bus.req_valid_in = '0;
         if (bus.req_ready_out[0]) begin
            bus.req_valid_in[0] = 1'b1; bus.req_addr_in[0] = 32'h200 + c0; c0++;
         end
         if (bus.req_ready_out[2]) begin
            bus.req_valid_in[2] = 1'b1; bus.req_addr_in[2] = 32'h300 + c2; c2++;
         end
         tick();
      end
      bus.req_valid_in = '0;
      chk("t3_r0_count", c0, 10);
      chk("t3_r2_count", c2, 10);
      tick(6);
      chk("t3_drained", mem_q.size() + resp_q.size(), 0);

      // backpressure: r3 holds valid while r0-r2 are ahead of it
      do_reset();
      t0 = cyc;
      exp_req(32'h400, 0, t0 + 2, mem_word(32'h400));
      exp_req(32'h401, 1, t0 + 3, mem_word(32'h401));
      exp_req(32'h402, 2, t0 + 4, mem_word(32'h402));
      exp_req(32'h430, 3, t0 + 5, mem_word(32'h430));
      exp_req(32'h435, 3, t0 + 7, mem_word(32'h435));
      for (int k = 0; k < 7; k++) begin
         if (k == 0) begin
            bus.req_valid_in = 4'hF;
            for (int i = 0; i < 3; i++) bus.req_addr_in[i] = 32'h400 + i;
            bus.req_addr_in[3] = 32'h430;
         end else if (k <= 5) begin
            bus.req_valid_in = 4'b1000;
            bus.req_addr_in[3] = 32'h430 + k;
         end else bus.req_valid_in = '0;
         if (k > 0) chk($sformatf("t4_ready3_k%0d", k), bus.req_ready_out[3], (k == 5));
         tick();
      end
      tick(5);
      chk("t4_drained", mem_q.size() + resp_q.size(), 0);

      // spurious mem_valid_in with empty tag pipeline
      do_reset();
      spur = 1'b1;
      chk("t5a_err_before", err_out, 0);
      tick();
      chk("t5a_err_rise", err_out, 1);
      tick(3);
      chk("t5a_err_sticky", err_out, 1);
      do_reset();
      chk_reset("t5a_cleared");

      // withheld response
      t0 = cyc;
      md_q.push_back('{32'h0, 1'b1});
      bus.req_valid_in = 4'b0100;
      bus.req_addr_in[2] = 32'h500;
      exp_issue(32'h500, t0 + 2);
      tick();
      bus.req_valid_in = '0;
      tick(3);
      chk("t5b_err_before", err_out, 0);
      tick();
      chk("t5b_err_set", err_out, 1);
      tick(2);
      chk("t5b_drained", mem_q.size() + resp_q.size(), 0);
      do_reset();

      // reset with 3 in flight and 2 pending
      t0 = cyc;
      bus.req_valid_in = 4'hF;
      for (int i = 0; i < N; i++) bus.req_addr_in[i] = 32'h600 + i;
      exp_issue(32'h600, t0 + 2);
      exp_issue(32'h601, t0 + 3);
      tick();
      bus.req_valid_in = '0;
      tick();
      bus.req_valid_in = 4'b0001;
      bus.req_addr_in[0] = 32'h610;
      tick();
      bus.req_valid_in = '0;
      tick();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      chk_reset("t6");
      chk("t6_issued", mem_q.size(), 0);
      tick(10);
      chk("t6_quiet", mem_q.size() + resp_q.size(), 0);
      chk("t6_idle", idle_out, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
